// File: rtl/vend_pkg.sv
// Shared types and constant tables for the coin credit front end.
package vend_pkg;

    localparam int unsigned CREDIT_W_DEFAULT = 10;

    typedef enum logic [1:0] {COIN_5, COIN_10, COIN_25, COIN_100} coin_type_t;

    // Coin values in cents, indexed by coin_type_t.
    localparam int unsigned COIN_VALUE [4] = '{5, 10, 25, 100};

    // Prices in cents, indexed by selection; entry 0 means no selection.
    localparam int unsigned PRICE_TABLE [8] = '{0, 75, 100, 65, 50, 125, 150, 90};

    typedef enum logic [1:0] {IDLE, ACCUM, PAID, CHANGE} acc_state_t;

endpackage

// File: rtl/escrow_timer.sv
// Inactivity counter for held credit; expires after TIMEOUT_CYCLES idle cycles while enabled.
module escrow_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clear,
    output logic o_expire
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] LastCount = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] r_count;

    // Activity in the expiring cycle wins, so a late coin still restarts the window.
    assign o_expire = i_en && !i_clear && (r_count == LastCount);

    always_ff @(posedge clk) begin
        if (rst || !i_en || i_clear) begin
            r_count <= '0;
        end else if (r_count != LastCount) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator feeding the vending controller. Optional escrow timeout via
// ESCROW_TIMEOUT_EN.
module coin_credit_accumulator
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W       = CREDIT_W_DEFAULT,
    parameter int unsigned MAX_CREDIT     = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic [2:0]          selection,
    input  logic                refund_req,
    input  logic                vend_done,
    input  logic                change_ack,
    output logic                paid,
    output logic [2:0]          sel_out,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount
);

    localparam logic [CREDIT_W:0] MaxCredit = (CREDIT_W + 1)'(MAX_CREDIT);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    acc_state_t          r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [CREDIT_W-1:0] r_change, w_change_nxt;
    logic [2:0]          r_sel, w_sel_nxt;
    logic                r_reject, w_reject_nxt;

    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W-1:0] w_price;
    logic [CREDIT_W-1:0] w_price_held;
    logic [CREDIT_W:0]   w_sum;
    logic                w_expire;

    assign w_coin_val   = CREDIT_W'(COIN_VALUE[coin_type_t'(coin_type)]);
    assign w_price      = CREDIT_W'(PRICE_TABLE[selection]);
    assign w_price_held = CREDIT_W'(PRICE_TABLE[r_sel]);
    // One extra bit so the overflow compare cannot wrap.
    assign w_sum        = {1'b0, r_credit} + {1'b0, w_coin_val};

`ifdef ESCROW_TIMEOUT_EN
    logic [2:0] r_sel_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_prev <= '0;
        end else begin
            r_sel_prev <= selection;
        end
    end

    escrow_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_escrow_timer (
        .clk     (clk),
        .rst     (rst),
        .i_en    (r_state == ACCUM),
        .i_clear (coin_valid || (selection != r_sel_prev)),
        .o_expire(w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_change_nxt = r_change;
        w_sel_nxt    = r_sel;
        w_reject_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (coin_valid) begin
                    w_credit_nxt = w_coin_val;
                    w_state_nxt  = ACCUM;
                end
            end
            ACCUM: begin
                if (refund_req || w_expire) begin
                    w_change_nxt = r_credit;
                    w_reject_nxt = coin_valid;
                    w_state_nxt  = CHANGE;
                end else if ((selection != 3'd0) && (r_credit >= w_price)) begin
                    w_sel_nxt    = selection;
                    w_reject_nxt = coin_valid;
                    w_state_nxt  = PAID;
                end else if (coin_valid) begin
                    if (w_sum <= MaxCredit) begin
                        w_credit_nxt = w_sum[CREDIT_W-1:0];
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end
            end
            PAID: begin
                w_reject_nxt = coin_valid;
                if (vend_done) begin
                    w_change_nxt = r_credit - w_price_held;
                    w_state_nxt  = CHANGE;
                end
            end
            CHANGE: begin
                w_reject_nxt = coin_valid;
                if (change_ack) begin
                    w_credit_nxt = '0;
                    w_change_nxt = '0;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_credit <= '0;
            r_change <= '0;
            r_sel    <= '0;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_change <= w_change_nxt;
            r_sel    <= w_sel_nxt;
            r_reject <= w_reject_nxt;
        end
    end

    assign paid          = (r_state == PAID);
    assign change_valid  = (r_state == CHANGE);
    assign sel_out       = r_sel;
    assign credit        = r_credit;
    assign coin_reject   = r_reject;
    assign change_amount = r_change;

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Directed bench for coin_credit_accumulator; timeout steps run only with ESCROW_TIMEOUT_EN.
module tb_coin_credit_accumulator;

    localparam int unsigned CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          coin_valid = 1'b0;
    logic [1:0]    coin_type = 2'd0;
    logic [2:0]    selection = 3'd0;
    logic          refund_req = 1'b0;
    logic          vend_done = 1'b0;
    logic          change_ack = 1'b0;
    logic          paid;
    logic [2:0]    sel_out;
    logic [CW-1:0] credit;
    logic          coin_reject;
    logic          change_valid;
    logic [CW-1:0] change_amount;

    int n_cmp = 0;
    int n_err = 0;

    coin_credit_accumulator #(
        .CREDIT_W      (CW),
        .MAX_CREDIT    (500),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .selection    (selection),
        .refund_req   (refund_req),
        .vend_done    (vend_done),
        .change_ack   (change_ack),
        .paid         (paid),
        .sel_out      (sel_out),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .change_valid (change_valid),
        .change_amount(change_amount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic ack();
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_credit", 32'(credit), 0);
        chk("rst_paid", 32'(paid), 0);
        chk("rst_change_valid", 32'(change_valid), 0);
        chk("rst_sel_out", 32'(sel_out), 0);
        chk("rst_coin_reject", 32'(coin_reject), 0);

        // IDLE ignores refund.
        refund_req = 1'b1;
        tick();
        refund_req = 1'b0;
        chk("idle_refund_ignored", 32'(change_valid), 0);

        // Exact payment 25+25+25 for selection 1 (price 75).
        selection = 3'd1;
        coin(2'd2);
        coin(2'd2);
        coin(2'd2);
        chk("t1_credit75", 32'(credit), 75);
        chk("t1_paid_not_yet", 32'(paid), 0);
        tick();
        chk("t1_paid", 32'(paid), 1);
        chk("t1_sel_out", 32'(sel_out), 1);
        vend_done = 1'b1;
        tick();
        vend_done = 1'b0;
        chk("t1_change_valid", 32'(change_valid), 1);
        chk("t1_change_zero", 32'(change_amount), 0);
        chk("t1_paid_low", 32'(paid), 0);
        ack();
        chk("t1_back_idle", 32'(change_valid), 0);
        chk("t1_credit_clr", 32'(credit), 0);

        // 100c for selection 3 (price 65), plus a coin rejected in PAID.
        selection = 3'd3;
        coin(2'd3);
        tick();
        chk("t2_paid", 32'(paid), 1);
        chk("t2_sel_out", 32'(sel_out), 3);
        selection = 3'd1;
        coin(2'd1);
        chk("t5_paid_reject", 32'(coin_reject), 1);
        chk("t5_paid_credit", 32'(credit), 100);
        chk("t5_sel_held", 32'(sel_out), 3);
        tick();
        chk("t5_reject_pulse", 32'(coin_reject), 0);
        vend_done = 1'b1;
        tick();
        vend_done = 1'b0;
        chk("t2_change35", 32'(change_amount), 35);
        chk("t2_change_valid", 32'(change_valid), 1);
        ack();

        // Fill to MAX_CREDIT then overflow.
        selection = 3'd0;
        for (int i = 0; i < 5; i++) coin(2'd3);
        chk("t3_credit500", 32'(credit), 500);
        chk("t3_no_reject_at_max", 32'(coin_reject), 0);
        coin(2'd0);
        chk("t3_overflow_reject", 32'(coin_reject), 1);
        chk("t3_credit_held", 32'(credit), 500);
        tick();
        chk("t3_reject_one_cycle", 32'(coin_reject), 0);
        refund_req = 1'b1;
        tick();
        refund_req = 1'b0;
        chk("t3_refund500", 32'(change_amount), 500);
        ack();

        // Refund and coin in the same cycle.
        coin(2'd2);
        coin(2'd1);
        chk("t4_credit35", 32'(credit), 35);
        refund_req = 1'b1;
        coin_valid = 1'b1;
        coin_type  = 2'd2;
        tick();
        refund_req = 1'b0;
        coin_valid = 1'b0;
        chk("t4_change_valid", 32'(change_valid), 1);
        chk("t4_change35", 32'(change_amount), 35);
        chk("t4_coin_reject", 32'(coin_reject), 1);
        chk("t4_credit_kept", 32'(credit), 35);
        coin(2'd0);
        chk("t4_change_coin_reject", 32'(coin_reject), 1);
        ack();

        // Mid-transaction reset with 60c held; coin in the reset cycle is discarded.
        coin(2'd2);
        coin(2'd2);
        coin(2'd1);
        chk("t5_credit60", 32'(credit), 60);
        rst        = 1'b1;
        coin_valid = 1'b1;
        tick();
        rst        = 1'b0;
        coin_valid = 1'b0;
        chk("t5_rst_credit", 32'(credit), 0);
        chk("t5_rst_reject", 32'(coin_reject), 0);
        chk("t5_rst_change_valid", 32'(change_valid), 0);
        chk("t5_rst_change_amt", 32'(change_amount), 0);
        chk("t5_rst_paid", 32'(paid), 0);
        chk("t5_rst_sel", 32'(sel_out), 0);
        refund_req = 1'b1;
        tick();
        refund_req = 1'b0;
        chk("t5_rst_idle", 32'(change_valid), 0);

`ifdef ESCROW_TIMEOUT_EN
        // Credit 10, idle for 16 cycles.
        coin(2'd1);
        for (int i = 0; i < 15; i++) tick();
        chk("t6_not_yet", 32'(change_valid), 0);
        tick();
        chk("t6_timeout", 32'(change_valid), 1);
        chk("t6_refund10", 32'(change_amount), 10);
        ack();
        // A coin at cycle 10 restarts the window.
        coin(2'd1);
        for (int i = 0; i < 9; i++) tick();
        coin(2'd0);
        chk("t6_restart_credit", 32'(credit), 15);
        for (int i = 0; i < 15; i++) tick();
        chk("t6_restart_not_yet", 32'(change_valid), 0);
        tick();
        chk("t6_restart_timeout", 32'(change_valid), 1);
        chk("t6_restart_refund", 32'(change_amount), 15);
        ack();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
